// File: rtl/dffc_clear_arbiter.sv
// dffc_clear_arbiter: round-robin sequencer that lends one shared
// asynchronous-clear register bank to N_REQ requesters, one at a time.
// For each granted requester it holds clr_out high for CLR_CYCLES cycles
// and then low for REC_CYCLES cycles. It then pulses done to that owner
// for one cycle.
// Optional feature macro: CLR_COUNT_EN adds the clr_count output, which is
// a wrapping count of the grants issued.
//
// Handshake: req[i] is a level. A requester raises it and keeps it high
// until it sees done[i]. gnt[i] is high from the grant edge through the
// recovery phase. done[i] is a single-cycle pulse that ends the sequence.
// The arbiter ignores all req while a sequence runs, so the owner may drop
// req at any time after the grant without shortening the clear. Other
// requesters are considered only after the arbiter returns to IDLE.
module dffc_clear_arbiter #(
  parameter int N_REQ      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int REC_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             c,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             clr_out,
  output logic             busy
`ifdef CLR_COUNT_EN
  ,
  output logic [CNT_W-1:0] clr_count
`endif
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int TMR_MAX = (CLR_CYCLES > REC_CYCLES) ? CLR_CYCLES : REC_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] REC_LOAD = TMR_W'(REC_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  localparam logic [2:0] S_RST_CLR = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_CLEAR   = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             clr_out_q, clr_out_d;
  logic             busy_q, busy_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] pick_cand;
  logic [N_REQ-1:0] pick_oh;
  logic [PTR_W-1:0] pick_next_ptr;

  // Round-robin search: first asserted req starting at ptr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pick_cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (!pick_found && req[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
    pick_next_ptr     = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
  end

  // Sequencer next-state: grant, clear, recover, done, back to idle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = done_q;
    clr_out_d = clr_out_q;
    busy_d    = busy_q;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    case (state_q)
      S_RST_CLR: begin
        // The reset clear is over. It still gets a recovery gap, but it has no owner.
        state_d   = S_RECOVER;
        clr_out_d = 1'b0;
        gnt_d     = '0;
        done_d    = '0;
        busy_d    = 1'b1;
        timer_d   = REC_LOAD;
      end
      S_IDLE: begin
        clr_out_d = 1'b0;
        done_d    = '0;
        busy_d    = 1'b0;
        if (pick_found) begin
          state_d   = S_CLEAR;
          gnt_d     = pick_oh;
          clr_out_d = 1'b1;
          busy_d    = 1'b1;
          timer_d   = CLR_LOAD;
          ptr_d     = pick_next_ptr;
        end
      end
      S_CLEAR: begin
        if (timer_q == '0) begin
          state_d   = S_RECOVER;
          clr_out_d = 1'b0;
          timer_d   = REC_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_RECOVER: begin
        if (timer_q == '0) begin
          gnt_d = '0;
          if (gnt_q != '0) begin
            // Owned sequence: the owner receives its done pulse.
            state_d = S_DONE;
            done_d  = gnt_q;
          end else begin
            // Recovery after reset: return straight to IDLE without a done pulse.
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        gnt_d     = '0;
        done_d    = '0;
        clr_out_d = 1'b0;
        busy_d    = 1'b0;
        timer_d   = '0;
      end
    endcase
  end

  // State registers. c forces the bank into clear and discards any sequence.
  always_ff @(posedge clk or posedge c) begin
    if (c) begin
      state_q   <= S_RST_CLR;
      gnt_q     <= '0;
      done_q    <= '0;
      clr_out_q <= 1'b1;
      busy_q    <= 1'b1;
      timer_q   <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      clr_out_q <= clr_out_d;
      busy_q    <= busy_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign clr_out = clr_out_q;
  assign busy    = busy_q;

`ifdef CLR_COUNT_EN
  logic [CNT_W-1:0] clr_count_q, clr_count_d;

  // Count grants only. The clear forced by reset is not a grant.
  always_comb begin
    clr_count_d = clr_count_q;
    if (state_q == S_IDLE && pick_found) begin
      clr_count_d = clr_count_q + 1'b1;
    end
  end

  // Grant counter register, cleared by c.
  always_ff @(posedge clk or posedge c) begin
    if (c) begin
      clr_count_q <= '0;
    end else begin
      clr_count_q <= clr_count_d;
    end
  end

  assign clr_count = clr_count_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_dffc_clear_arbiter.sv
// Bench for dffc_clear_arbiter (defaults N_REQ=4, CLR_CYCLES=2, REC_CYCLES=1).
// The reference model tracks the owner and the number of edges since the
// grant. All outputs are derived from those two values.
// Define CLR_COUNT_EN to also exercise clr_count.
module tb_dffc_clear_arbiter;

  localparam int N   = 4;
  localparam int CLR = 2;
  localparam int REC = 1;
  localparam int CW  = 8;

  logic         clk;
  logic         c;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         clr_out;
  logic         busy;
`ifdef CLR_COUNT_EN
  logic [CW-1:0] clr_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_ptr;
  int m_owner;
  int m_age;
  int m_rst_left;
  int m_count;

  // observation helpers
  int cyc;
  int obs_clr_hi;
  int obs_done_hits;
  logic [N-1:0] rnd_req;
  logic [N-1:0] prev_gnt;
  int g_owner_q[$];
  int g_cycle_q[$];
  int exp_order[5];

  dffc_clear_arbiter #(
    .N_REQ(N), .CLR_CYCLES(CLR), .REC_CYCLES(REC), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .c(c),
    .req(req),
    .gnt(gnt),
    .done(done),
    .clr_out(clr_out),
    .busy(busy)
`ifdef CLR_COUNT_EN
    ,
    .clr_count(clr_count)
`endif
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int owner_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr      = 0;
    m_owner    = -1;
    m_age      = 0;
    m_rst_left = REC + 1;
    m_count    = 0;
  endfunction

  // One clock edge of the model, using the req value present at that edge.
  function automatic void model_edge(input logic [N-1:0] r);
    if (m_rst_left > 0) begin
      m_rst_left--;
    end else if (m_owner >= 0) begin
      m_age++;
      if (m_age >= CLR + REC + 1) m_owner = -1;
    end else if (r != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (r[idx]) begin
          m_owner = idx;
          m_age   = 0;
          m_ptr   = (idx + 1) % N;
          m_count++;
          break;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_done;
    logic         e_clr;
    logic         e_busy;
    e_gnt  = (m_owner >= 0 && m_age < CLR + REC) ? onehot(m_owner) : '0;
    e_done = (m_owner >= 0 && m_age == CLR + REC) ? onehot(m_owner) : '0;
    e_clr  = c ? 1'b1 : (m_owner >= 0 && m_age < CLR);
    e_busy = c || (m_rst_left > 0) || (m_owner >= 0);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".clr_out"}, 32'(clr_out), 32'(e_clr));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
`ifdef CLR_COUNT_EN
    chk({tag, ".clr_count"}, 32'(clr_count), 32'(m_count % (1 << CW)));
`endif
  endtask

  // Drive req for the next edge, advance one cycle, then check #1 after the edge.
  task automatic tick(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    #1;
    cyc++;
    if (!c) model_edge(r);
    if (clr_out === 1'b1) obs_clr_hi++;
    if (done !== '0) obs_done_hits++;
    check_all(tag);
  endtask

  // Assert c asynchronously in mid-cycle, hold it over one edge, then release it.
  task automatic pulse_reset(input string tag);
    c = 1'b1;
    model_reset();
    #2;
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_hold"});
    c = 1'b0;
  endtask

  task automatic clear_obs();
    obs_clr_hi    = 0;
    obs_done_hits = 0;
  endtask

  initial begin
    cyc = 0;
    clear_obs();
    model_reset();

    // reset held for 12 ns
    c   = 1'b1;
    req = '0;
    #12;
    check_all("rst_hold");
    chk("rst_hold_clr_const", 32'(clr_out), 32'd1);
    c = 1'b0;
    tick('0, "rst_rel1");
    chk("rst_rel1_clr_const", 32'(clr_out), 32'd0);
    chk("rst_rel1_busy_const", 32'(busy), 32'd1);
    tick('0, "rst_rel2");
    chk("rst_rel2_busy_const", 32'(busy), 32'd0);

    // single requester 0100, held until done
    clear_obs();
    tick(4'b0100, "s1_grant");
    chk("s1_gnt_const", 32'(gnt), 32'(4'b0100));
    for (int i = 0; i < 3; i++) tick(4'b0100, "s1_seq");
    for (int i = 0; i < 2; i++) tick('0, "s1_tail");
    chk("s1_clr_width", 32'(obs_clr_hi), 32'd2);
    chk("s1_done_count", 32'(obs_done_hits), 32'd1);

    // all four requesting: order 0,1,2,3,0 from a fresh pointer, every 5 cycles
    pulse_reset("rr_rst");
    tick('0, "rr_rel1");
    tick('0, "rr_rel2");
    clear_obs();
    g_owner_q.delete();
    g_cycle_q.delete();
    prev_gnt = '0;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 26; i++) begin
      tick((i < 21) ? 4'b1111 : 4'b0000, "rr_seq");
      if (gnt != '0 && prev_gnt == '0) begin
        g_owner_q.push_back(owner_of(gnt));
        g_cycle_q.push_back(cyc);
      end
      prev_gnt = gnt;
    end
    chk("rr_grant_count", 32'(g_owner_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < g_owner_q.size(); i++) begin
      chk($sformatf("rr_order%0d", i), 32'(g_owner_q[i]), 32'(exp_order[i]));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(g_cycle_q[i] - g_cycle_q[i-1]), 32'd5);
    end
    chk("rr_done_count", 32'(obs_done_hits), 32'd5);

    // req[1] dropped one cycle after grant
    clear_obs();
    tick(4'b0010, "drop_grant");
    chk("drop_gnt_const", 32'(gnt), 32'(4'b0010));
    for (int i = 0; i < 5; i++) tick('0, "drop_seq");
    chk("drop_clr_width", 32'(obs_clr_hi), 32'd2);
    chk("drop_done_count", 32'(obs_done_hits), 32'd1);

    // c asserted mid-CLEAR while requester 1 owns the bank
    tick(4'b0010, "midrst_grant");
    chk("midrst_gnt_before", 32'(gnt), 32'(4'b0010));
    pulse_reset("midrst");
    chk("midrst_gnt_const", 32'(gnt), 32'd0);
    tick(4'b1010, "midrst_rel1");
    tick(4'b1010, "midrst_rel2");
    tick(4'b1010, "midrst_regrant");
    chk("midrst_regrant_const", 32'(gnt), 32'(4'b0010));
    for (int i = 0; i < 5; i++) tick('0, "midrst_tail");

    // randomized traffic with occasional asynchronous resets
    rnd_req = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        if ($urandom_range(0, 1) == 1) rnd_req = N'($urandom_range(0, (1 << N) - 1));
        tick(rnd_req, "rnd");
      end
    end

`ifdef CLR_COUNT_EN
    // 300 single-requester sequences: 300 mod 256 = 44
    pulse_reset("cnt_rst");
    for (int g = 0; g < 2500 && m_count < 300; g++) begin
      tick(onehot($urandom_range(0, N - 1)), "cnt");
    end
    chk("cnt_wrap_const", 32'(clr_count), 32'd44);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
